countdown_seq: RTL and testbench
================================

Name: countdown_seq

Overview:
- Parametrised countdown sequencer for the game's pre-round delay: shows N, N-1, …, 1 and then a "GO" glyph on the 7-segment digit bus, one step per tick period.
- Asserts a completion flag when the GO period ends.
- Sits between the game-control FSM (start/pause/abort) and the display mux.
- Adds a run-time start value, pause, abort/restart, a one-cycle done pulse and a busy flag.

Parameters:
- TICK_CYCLES, 100_000_000, clock cycles per displayed step (1 s at 100 MHz); must be ≥ 2.
- GO_CYCLES, 100_000_000, clock cycles the GO glyph is shown before completion; must be ≥ 2.
- DIGITS, 4, number of 4-bit display digits on data.
- MAX_COUNT, 9, largest allowed start value; larger requests clamp to this.
- GO_PATTERN, 16'h9AFF, digit codes for the GO glyph; width 4*DIGITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high (the block resets while rst_n=1)
- start  in  1  one-cycle request to begin a countdown
- load_count  in  4  start value N, sampled only on an accepted start
- pause  in  1  level; freezes the sequence while high
- abort  in  1  one-cycle request to cancel and blank the display
- data  out  4*DIGITS  digit codes; MS digit = current count, all other digits = 4'hF (blank)
- busy  out  1  high in COUNT or GO
- tick  out  1  one-cycle pulse on every step boundary
- done  out  1  one-cycle pulse when GO ends
- delayover  out  1  level; high in OVER until the next accepted start or an abort

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE, tick counter=0, count=0.
  - data=all 4'hF; busy, tick, done, delayover all 0.
- States: IDLE, COUNT, GO, OVER; encoded 2 bits.
- Start acceptance:
  - start is accepted in IDLE or OVER when abort=0. It is ignored in COUNT/GO.
  - On acceptance at edge t:
    - count = min(load_count, MAX_COUNT); tick counter = 0; delayover = 0.
    - If count ≠ 0: state = COUNT, data = {count, F…F}.
    - If count = 0: state = GO, data = GO_PATTERN.
  - All of these are visible at t+1; busy = 1 from t+1.
- Tick counter:
  - Counts 0..limit-1, where limit = TICK_CYCLES in COUNT and GO_CYCLES in GO.
  - Advances only when pause=0. It holds its value, and no tick is generated, while pause=1.
  - A step boundary is the edge where counter = limit-1 and pause=0. At that edge the counter wraps to 0 and tick=1 for the following cycle.
- COUNT boundary:
  - If count > 1: count decrements and data updates to the new value on the same edge.
  - If count = 1: state = GO, data = GO_PATTERN.
- GO boundary:
  - state = OVER; delayover = 1; done = 1 for exactly one cycle; busy = 0.
  - data holds GO_PATTERN.
- OVER: holds until an accepted start (restart) or abort.
- Abort:
  - Abort in any state gives IDLE, data all F, busy/delayover = 0 and counter = 0 at the next edge.
  - Abort takes priority over start, pause and step boundary in the same cycle; no tick/done is emitted that cycle.
- Pause coincident with a boundary: pause wins; the boundary occurs on the first unpaused cycle.
- Counter width: $clog2(max(TICK_CYCLES, GO_CYCLES)); no wrap beyond limit-1.
- Total duration for start value N, unpaused: N*TICK_CYCLES + GO_CYCLES cycles from acceptance to done.

Decomposition:
- Package countdown_pkg holds:
  - state enum (IDLE=0, COUNT=1, GO=2, OVER=3);
  - BLANK_DIGIT = 4'hF;
  - default GO_PATTERN;
  - a function that builds {digit, blanks} for a given DIGITS.
- One sub-module, tick_divider:
  - parameters: max limit;
  - inputs: clk, rst_n, enable, clear, limit;
  - output: wrap pulse.
  - The top level holds the FSM, count register and data formatting.

Test Plan (TICK_CYCLES=4, GO_CYCLES=3, DIGITS=4):
1. Reset then start with load_count=3:
   - data=3FFF at t+1, 2FFF at t+5, 1FFF at t+9, 9AFF at t+13.
   - done pulse and delayover=1 at t+16; busy low at t+16.
   - tick pulses at t+5, t+9, t+13, t+16.
2. load_count=0 → data=9AFF at t+1, done at t+4. load_count=12 → clamps, data=9FFF at t+1.
3. load_count=2, pause high for 5 cycles starting at t+2 → 1FFF appears 5 cycles late (t+10); no tick while paused; pause held exactly on a boundary cycle delays that boundary.
4. Abort while data=2FFF, with start asserted the same cycle → next cycle data=FFFF, busy=0, no done; start ignored.
5. Start asserted in COUNT → ignored, sequence timing unchanged. Start in OVER → delayover drops at t+1, new countdown runs.
6. Assert rst_n mid-GO, asynchronously between edges → all outputs at reset values immediately; after release, IDLE until next start.

Source files
------------

// File: rtl/countdown_seq_pkg.sv
// Shared types and display helpers for the pre-round countdown sequencer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    GO    = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [3:0]  BLANK_DIGIT        = 4'hF;
  localparam logic [15:0] DEFAULT_GO_PATTERN = 16'h9AFF;
  localparam int          MAX_DIGITS         = 16;
  localparam int          WORD_W             = 4 * MAX_DIGITS;

  // Places digit in the most significant of `digits` positions, every other
  // position blank; callers keep only the low 4*digits bits.
  function automatic logic [WORD_W-1:0] digit_word(input logic [3:0] digit,
                                                    input int         digits);
    return ~(WORD_W'(~digit) << (4 * (digits - 1)));
  endfunction

endpackage

// File: rtl/countdown_seq_if.sv
// Control/display bundle between the game-control FSM and the countdown sequencer.
interface countdown_seq_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [3:0]            load_count;
  logic                  pause;
  logic                  abort;
  logic [4*DIGITS-1:0]   data;
  logic                  busy;
  logic                  tick;
  logic                  done;
  logic                  delayover;

  modport master (
    output start, load_count, pause, abort,
    input  data, busy, tick, done, delayover
  );

  modport slave (
    input  start, load_count, pause, abort,
    output data, busy, tick, done, delayover
  );
endinterface

// File: rtl/countdown_seq_tick_divider.sv
// Free-running step counter: counts 0..limit-1 while enabled and flags the wrap cycle.
module tick_divider #(
  parameter  int MAX_LIMIT = 4,
  localparam int CW        = $clog2(MAX_LIMIT),
  localparam int LW        = $clog2(MAX_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic [LW-1:0] limit,
  output logic          wrap
);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (LW'(cnt) == limit - LW'(1));
  assign wrap    = enable && !clear && at_last;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_seq.sv
// Countdown sequencer: shows N..1 then the GO glyph, one step per tick period.
module countdown_seq
  import countdown_pkg::*;
#(
  parameter int                  TICK_CYCLES = 100_000_000,
  parameter int                  GO_CYCLES   = 100_000_000,
  parameter int                  DIGITS      = 4,
  parameter int                  MAX_COUNT   = 9,
  parameter logic [4*DIGITS-1:0] GO_PATTERN  = DEFAULT_GO_PATTERN
) (
  input logic            clk,
  input logic            rst_n,
  countdown_seq_if.slave bus
);

  localparam int              MAX_LIMIT  = (TICK_CYCLES > GO_CYCLES) ? TICK_CYCLES : GO_CYCLES;
  localparam int              LW         = $clog2(MAX_LIMIT + 1);
  localparam int              DW         = 4 * DIGITS;
  localparam logic [DW-1:0]   BLANK_WORD = {DIGITS{BLANK_DIGIT}};

  state_t          state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic [3:0]      start_value;
  logic [DW-1:0]   data_q, data_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic            accept, enable, clear, wrap;
  logic [LW-1:0]   limit;

  function automatic logic [DW-1:0] show(input logic [3:0] digit);
    logic [WORD_W-1:0] w;
    w = digit_word(digit, DIGITS);
    return w[DW-1:0];
  endfunction

  assign start_value = (bus.load_count > 4'(MAX_COUNT)) ? 4'(MAX_COUNT) : bus.load_count;
  assign accept      = bus.start && !bus.abort && (state_q == IDLE || state_q == OVER);
  assign enable      = (state_q == COUNT || state_q == GO) && !bus.pause;
  assign clear       = bus.abort || accept;
  assign limit       = (state_q == GO) ? LW'(GO_CYCLES) : LW'(TICK_CYCLES);

  tick_divider #(
    .MAX_LIMIT(MAX_LIMIT)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .clear (clear),
    .limit (limit),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= BLANK_WORD;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
      data_d  = BLANK_WORD;
    end else if (accept) begin
      count_d = start_value;
      if (start_value != 4'd0) begin
        state_d = COUNT;
        data_d  = show(start_value);
      end else begin
        state_d = GO;
        data_d  = GO_PATTERN;
      end
    end else if (wrap) begin
      tick_d = 1'b1;
      case (state_q)
        COUNT: begin
          if (count_q > 4'd1) begin
            count_d = count_q - 4'd1;
            data_d  = show(count_q - 4'd1);
          end else begin
            state_d = GO;
            count_d = '0;
            data_d  = GO_PATTERN;
          end
        end
        GO: begin
          state_d = OVER;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.busy      = (state_q == COUNT) || (state_q == GO);
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
  assign bus.delayover = (state_q == OVER);

endmodule

// File: tb/tb_countdown_seq.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_countdown_seq;

  localparam int          TICK   = 4;
  localparam int          GOC    = 3;
  localparam int          DIGITS = 4;
  localparam int          MAXC   = 9;
  localparam logic [15:0] GOP    = 16'h9AFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  countdown_seq_if #(.DIGITS(DIGITS)) bus ();

  countdown_seq #(
    .TICK_CYCLES(TICK),
    .GO_CYCLES  (GOC),
    .DIGITS     (DIGITS),
    .MAX_COUNT  (MAXC),
    .GO_PATTERN (GOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running sequence is just "unpaused cycles elapsed since start".
  bit m_run = 1'b0, m_over = 1'b0, m_tick = 1'b0, m_done = 1'b0, cmp_en = 1'b0;
  int m_n = 0, m_act = 0;

  function automatic logic [15:0] m_data();
    if (m_run) begin
      if (m_act < m_n * TICK) return {4'(m_n - m_act / TICK), 12'hFFF};
      return GOP;
    end
    if (m_over) return GOP;
    return 16'hFFFF;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_over = 1'b0; m_tick = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_update(input bit s, input int l, input bit p, input bit a);
    m_tick = 1'b0;
    m_done = 1'b0;
    if (rst_n || a) begin
      model_reset();
    end else if (s && !m_run) begin
      m_n = (l > MAXC) ? MAXC : l;
      m_act = 0; m_run = 1'b1; m_over = 1'b0;
    end else if (m_run && !p) begin
      m_act++;
      if (m_act == m_n * TICK + GOC) begin
        m_tick = 1'b1; m_done = 1'b1; m_run = 1'b0; m_over = 1'b1;
      end else if (m_act % TICK == 0 && m_act <= m_n * TICK) begin
        m_tick = 1'b1;
      end
    end
  endtask

  // Drives one cycle's inputs, lets the edge happen, returns at the next falling edge.
  task automatic cycle(input bit s, input int l, input bit p, input bit a);
    bus.start = s; bus.load_count = 4'(l); bus.pause = p; bus.abort = a;
    @(posedge clk);
    #1;
    model_update(s, l, p, a);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_data", bus.data, m_data());
      check("cmp_busy", bus.busy, m_run);
      check("cmp_tick", bus.tick, m_tick);
      check("cmp_done", bus.done, m_done);
      check("cmp_delayover", bus.delayover, m_over);
    end
  end

  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0; bus.load_count = '0; bus.pause = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", bus.data, 16'hFFFF);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_delayover", bus.delayover, 1'b0);
    rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) cycle(0, 0, 0, 0);

    // Scenario 1: full countdown from 3.
    cycle(1, 3, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 1)  check("s1_data_t1", bus.data, 16'h3FFF);
      if (k == 4)  check("s1_tick_t4", bus.tick, 1'b0);
      if (k == 5)  begin check("s1_data_t5", bus.data, 16'h2FFF); check("s1_tick_t5", bus.tick, 1'b1); end
      if (k == 9)  begin check("s1_data_t9", bus.data, 16'h1FFF); check("s1_tick_t9", bus.tick, 1'b1); end
      if (k == 13) begin check("s1_data_t13", bus.data, 16'h9AFF); check("s1_tick_t13", bus.tick, 1'b1); end
      if (k == 15) begin check("s1_done_t15", bus.done, 1'b0); check("s1_busy_t15", bus.busy, 1'b1); end
      if (k == 16) begin
        check("s1_done_t16", bus.done, 1'b1);
        check("s1_over_t16", bus.delayover, 1'b1);
        check("s1_busy_t16", bus.busy, 1'b0);
        check("s1_tick_t16", bus.tick, 1'b1);
      end
      cycle(0, 0, 0, 0);
    end
    check("s1_done_once", bus.done, 1'b0);

    // Scenario 2: zero start value goes straight to GO; oversize value clamps.
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) begin check("s2_go_t1", bus.data, 16'h9AFF); check("s2_over_drop", bus.delayover, 1'b0); end
      if (k == 4) check("s2_done_t4", bus.done, 1'b1);
      if (k < 4) cycle(0, 0, 0, 0);
    end
    cycle(1, 12, 0, 0);
    check("s2_clamp", bus.data, 16'h9FFF);
    cycle(0, 0, 0, 1);

    // Scenario 3: pause stretches a step; pause on a boundary cycle defers it.
    cycle(1, 2, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 9)  check("s3_data_t9", bus.data, 16'h2FFF);
      if (k == 10) begin check("s3_data_t10", bus.data, 16'h1FFF); check("s3_tick_t10", bus.tick, 1'b1); end
      if (k == 14) begin check("s3_data_t14", bus.data, 16'h1FFF); check("s3_tick_t14", bus.tick, 1'b0); end
      if (k == 15) check("s3_data_t15", bus.data, 16'h9AFF);
      cycle(0, 0, (k >= 2 && k <= 6) || k == 13, 0);
    end
    cycle(0, 0, 0, 1);

    // Scenario 4: abort with a simultaneous start.
    cycle(1, 3, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    check("s4_before", bus.data, 16'h2FFF);
    cycle(1, 5, 0, 1);
    check("s4_data", bus.data, 16'hFFFF);
    check("s4_busy", bus.busy, 1'b0);
    check("s4_done", bus.done, 1'b0);
    repeat (3) cycle(0, 0, 0, 0);
    check("s4_stay_idle", bus.busy, 1'b0);

    // Scenario 5: start ignored mid-count, honoured in OVER.
    cycle(1, 2, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 5)  check("s5_data_t5", bus.data, 16'h1FFF);
      if (k == 9)  check("s5_data_t9", bus.data, 16'h9AFF);
      if (k == 12) check("s5_done_t12", bus.done, 1'b1);
      if (k < 12) cycle(k == 3, 7, 0, 0);
    end
    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check("s5_restart_over", bus.delayover, 1'b0);
    check("s5_restart_data", bus.data, 16'h1FFF);
    check("s5_restart_busy", bus.busy, 1'b1);

    // Scenario 6: asynchronous reset in the middle of GO.
    repeat (5) cycle(0, 0, 0, 0);
    check("s6_in_go", bus.data, 16'h9AFF);
    #2 rst_n = 1'b1;
    #1;
    model_reset();
    check("s6_async_data", bus.data, 16'hFFFF);
    check("s6_async_busy", bus.busy, 1'b0);
    check("s6_async_tick", bus.tick, 1'b0);
    check("s6_async_done", bus.done, 1'b0);
    check("s6_async_over", bus.delayover, 1'b0);
    repeat (2) cycle(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) cycle(0, 0, 0, 0);
    check("s6_idle_after", bus.data, 16'hFFFF);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(7) == 0, int'($urandom_range(15)),
            $urandom_range(4) == 0, $urandom_range(39) == 0);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
